// File: rtl/display_mux_ctrl.sv
// Time-multiplexing controller for a dual seven-segment display: alternates s1/s2
// onto one shared decoder nibble, with active-low anode enables and inter-digit blanking.
module display_mux_ctrl #(
  parameter int DWELL = 100000,
  parameter int BLANK = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] s1,
  input  logic [3:0] s2,
  output logic [3:0] nibble,
  output logic [1:0] enable,
  output logic       frame_done
);

  localparam int MAX_LEN = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = (BLANK == 0) ? '0 : CNT_W'(BLANK - 1);

  typedef enum logic [1:0] {
    ST_BLANK0 = 2'd0,
    ST_SHOW0  = 2'd1,
    ST_BLANK1 = 2'd2,
    ST_SHOW1  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       nibble_q, nibble_d;
  logic [1:0]       enable_q, enable_d;
  logic             frame_done_q, frame_done_d;
  logic             is_show;
  logic             phase_end;

  // State, phase counter and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_BLANK0;
      cnt_q        <= '0;
      nibble_q     <= 4'h0;
      enable_q     <= 2'b11;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      nibble_q     <= nibble_d;
      enable_q     <= enable_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next-state sequencing; with no blanking a BLANK state ends on its first cycle
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    nibble_d     = nibble_q;
    enable_d     = enable_q;
    frame_done_d = 1'b0;

    is_show   = (state_q == ST_SHOW0) || (state_q == ST_SHOW1);
    phase_end = is_show ? (cnt_q == DWELL_LAST)
                        : ((BLANK == 0) || (cnt_q == BLANK_LAST));

    if (phase_end) begin
      cnt_d        = '0;
      frame_done_d = (state_q == ST_SHOW1);
      case (state_q)
        ST_BLANK0: state_d = ST_SHOW0;
        ST_SHOW0:  state_d = (BLANK == 0) ? ST_SHOW1 : ST_BLANK1;
        ST_BLANK1: state_d = ST_SHOW1;
        ST_SHOW1:  state_d = (BLANK == 0) ? ST_SHOW0 : ST_BLANK0;
        default:   state_d = ST_BLANK0;
      endcase
    end else begin
      state_d = state_q;
    end

    case (state_d)
      ST_SHOW0: enable_d = 2'b10;
      ST_SHOW1: enable_d = 2'b01;
      default:  enable_d = 2'b11;
    endcase

    // Inputs are sampled only on the edge entering a SHOW phase
    if (phase_end && (state_d == ST_SHOW0)) begin
      nibble_d = s1;
    end else if (phase_end && (state_d == ST_SHOW1)) begin
      nibble_d = s2;
    end else begin
      nibble_d = nibble_q;
    end
  end

  assign nibble     = nibble_q;
  assign enable     = enable_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_mux_ctrl.sv
// Directed bench for display_mux_ctrl: three parameterisations run side by side
// (DWELL/BLANK = 4/2, 3/0, 1/1) sharing clock and reset.
module tb_display_mux_ctrl;

  logic       clk;
  logic       reset;
  logic [3:0] s1_a, s2_a, s1_b, s2_b, s1_c, s2_c;
  logic [3:0] nib_a, nib_b, nib_c;
  logic [1:0] en_a, en_b, en_c;
  logic       fd_a, fd_b, fd_c;
  logic [3:0] exp_nib_a, exp_nib_b, exp_nib_c;
  int         n_checks;
  int         n_pass;

  display_mux_ctrl #(.DWELL(4), .BLANK(2)) dut_a (
    .clk(clk), .reset(reset), .s1(s1_a), .s2(s2_a),
    .nibble(nib_a), .enable(en_a), .frame_done(fd_a)
  );

  display_mux_ctrl #(.DWELL(3), .BLANK(0)) dut_b (
    .clk(clk), .reset(reset), .s1(s1_b), .s2(s2_b),
    .nibble(nib_b), .enable(en_b), .frame_done(fd_b)
  );

  display_mux_ctrl #(.DWELL(1), .BLANK(1)) dut_c (
    .clk(clk), .reset(reset), .s1(s1_c), .s2(s2_c),
    .nibble(nib_c), .enable(en_c), .frame_done(fd_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_checks++;
    if (obs === expv) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Phase after t edges since reset release: 0=BLANK0 1=SHOW0 2=BLANK1 3=SHOW1
  function automatic int st(input int t, input int d, input int b);
    int p;
    if (b == 0) begin
      if (t == 0) return 0;
      p = (t - 1) % (2 * d);
      return (p < d) ? 1 : 3;
    end
    p = t % (2 * (d + b));
    if (p < b)         return 0;
    if (p < b + d)     return 1;
    if (p < 2 * b + d) return 2;
    return 3;
  endfunction

  function automatic logic [1:0] en_of(input int s);
    if (s == 1) return 2'b10;
    if (s == 3) return 2'b01;
    return 2'b11;
  endfunction

  task automatic check_dut(input string name, input int t, input int d, input int b,
                           input logic [3:0] nib_obs, input logic [1:0] en_obs,
                           input logic fd_obs, input logic [3:0] nib_exp);
    logic fd_exp;
    fd_exp = (t > 0) && (st(t - 1, d, b) == 3) && (st(t, d, b) != 3);
    check($sformatf("%s t=%0d enable", name, t), {6'd0, en_obs}, {6'd0, en_of(st(t, d, b))});
    check($sformatf("%s t=%0d enable!=00", name, t), {7'd0, en_obs == 2'b00}, 8'd0);
    check($sformatf("%s t=%0d nibble", name, t), {4'd0, nib_obs}, {4'd0, nib_exp});
    check($sformatf("%s t=%0d frame_done", name, t), {7'd0, fd_obs}, {7'd0, fd_exp});
  endtask

  task automatic check_all(input int t);
    check_dut("A", t, 4, 2, nib_a, en_a, fd_a, exp_nib_a);
    check_dut("B", t, 3, 0, nib_b, en_b, fd_b, exp_nib_b);
    check_dut("C", t, 1, 1, nib_c, en_c, fd_c, exp_nib_c);
  endtask

  task automatic check_reset(input string tag);
    check({tag, " A enable"}, {6'd0, en_a}, 8'h03);
    check({tag, " A nibble"}, {4'd0, nib_a}, 8'h00);
    check({tag, " A frame_done"}, {7'd0, fd_a}, 8'h00);
    check({tag, " B enable"}, {6'd0, en_b}, 8'h03);
    check({tag, " B nibble"}, {4'd0, nib_b}, 8'h00);
    check({tag, " C enable"}, {6'd0, en_c}, 8'h03);
    check({tag, " C frame_done"}, {7'd0, fd_c}, 8'h00);
  endtask

  // Expected nibble latches the input driven just before the edge entering a SHOW
  task automatic track(input int t);
    if (st(t, 4, 2) != st(t - 1, 4, 2)) begin
      if (st(t, 4, 2) == 1) exp_nib_a = s1_a;
      if (st(t, 4, 2) == 3) exp_nib_a = s2_a;
    end
    if (st(t, 3, 0) != st(t - 1, 3, 0)) begin
      if (st(t, 3, 0) == 1) exp_nib_b = s1_b;
      if (st(t, 3, 0) == 3) exp_nib_b = s2_b;
    end
    if (st(t, 1, 1) != st(t - 1, 1, 1)) begin
      if (st(t, 1, 1) == 1) exp_nib_c = s1_c;
      if (st(t, 1, 1) == 3) exp_nib_c = s2_c;
    end
  endtask

  task automatic run(input int t_to, input bit randomize_in);
    for (int t = 1; t <= t_to; t++) begin
      track(t);
      @(posedge clk);
      #2;
      check_all(t);
      if (!randomize_in) begin
        if (t == 4)  check("A hold s1 mid-SHOW0", {4'd0, nib_a}, 8'h03);
        if (t == 9)  check("A SHOW1 nibble", {4'd0, nib_a}, 8'h0A);
        if (t == 12) check("A frame pulse", {7'd0, fd_a}, 8'h01);
        if (t == 15) check("A new s1 next frame", {4'd0, nib_a}, 8'h07);
        if (t == 3)  s1_a = 4'h7;
      end else begin
        s1_a = 4'($urandom_range(0, 15));
        s2_a = 4'($urandom_range(0, 15));
        s1_b = 4'($urandom_range(0, 15));
        s2_b = 4'($urandom_range(0, 15));
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset = 1'b1;
    s1_a = 4'h3; s2_a = 4'hA;
    s1_b = 4'h5; s2_b = 4'hC;
    s1_c = 4'h9; s2_c = 4'h1;
    exp_nib_a = 4'h0; exp_nib_b = 4'h0; exp_nib_c = 4'h0;

    repeat (2) @(posedge clk);
    #2;
    check_reset("reset");
    reset = 1'b0;
    check_all(0);
    run(45, 1'b0);

    // DUT A is now mid-SHOW1; reset must act without a clock edge
    #1;
    reset = 1'b1;
    #1;
    check_reset("async reset");
    repeat (3) @(posedge clk);
    #2;
    check_reset("reset held");
    reset = 1'b0;
    exp_nib_a = 4'h0; exp_nib_b = 4'h0; exp_nib_c = 4'h0;
    check_all(0);
    run(240, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
